// File: rtl/seq_det_param_if.sv
// Serial pattern detector bus: qualified bit stream and pattern control in,
// match pulse and match counter status out.
interface seq_det_param_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             seq_bit;
   logic             bit_vld;
   logic             overlap;
   logic             pat_load;
   logic [PAT_W-1:0] pat_in;
   logic             clr_cnt;
   logic             tick;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;

   modport master (
      output seq_bit, bit_vld, overlap, pat_load, pat_in, clr_cnt,
      input  tick, match_cnt, cnt_sat
   );

   modport slave (
      input  seq_bit, bit_vld, overlap, pat_load, pat_in, clr_cnt,
      output tick, match_cnt, cnt_sat
   );
endinterface

// File: rtl/seq_det_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern,
// overlap select, registered match pulse and saturating match counter.
module seq_det_param #(
   parameter int               PAT_W       = 4,
   parameter logic [PAT_W-1:0] PAT_DEFAULT = PAT_W'(4'b1011),
   parameter int               CNT_W       = 8
) (
   input logic            clk,
   input logic            rst,
   seq_det_param_if.slave bus
);
   localparam int               FILL_W  = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_W - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX = '1;

   logic [PAT_W-2:0]  hist;
   logic [FILL_W-1:0] fill;
   logic [PAT_W-1:0]  pat;
   logic [PAT_W-1:0]  window;
   logic              match;
   logic              tick;
   logic [CNT_W-1:0]  cnt;

   // newest bit joins the history at the LSB end
   assign window = {hist, bus.seq_bit};

   assign match = bus.bit_vld & ~bus.pat_load &
                  (fill == FULL) & (window == pat);

   // pattern, history and fill tracking
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat  <= PAT_DEFAULT;
         hist <= '0;
         fill <= '0;
      end else if (bus.pat_load) begin
         pat  <= bus.pat_in;
         fill <= '0;
      end else if (bus.bit_vld) begin
         hist <= window[PAT_W-2:0];
         if (match && !bus.overlap)
            fill <= '0;
         else if (fill != FULL)
            fill <= fill + 1'b1;
      end
   end

   // match pulse and saturating counter, clear wins over a match
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick <= 1'b0;
         cnt  <= '0;
      end else begin
         tick <= match;
         if (bus.clr_cnt)
            cnt <= '0;
         else if (match && cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
      end
   end

   assign bus.tick      = tick;
   assign bus.match_cnt = cnt;
   assign bus.cnt_sat   = (cnt == CNT_MAX);
endmodule

// File: tb/tb_seq_det_param.sv
// Directed testbench for seq_det_param: one main instance (CNT_W=8) and a
// narrow-counter instance (CNT_W=2) fed the same stimulus.
module tb_seq_det_param;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   seq_det_param_if #(.PAT_W(4), .CNT_W(8)) bus ();
   seq_det_param_if #(.PAT_W(4), .CNT_W(2)) bus2 ();

   assign bus2.seq_bit  = bus.seq_bit;
   assign bus2.bit_vld  = bus.bit_vld;
   assign bus2.overlap  = bus.overlap;
   assign bus2.pat_load = bus.pat_load;
   assign bus2.pat_in   = bus.pat_in;
   assign bus2.clr_cnt  = bus.clr_cnt;

   seq_det_param #(.PAT_W(4), .PAT_DEFAULT(4'b1011), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   seq_det_param #(.PAT_W(4), .PAT_DEFAULT(4'b1011), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .bus(bus2)
   );

   task automatic drive(input logic b, input logic v);
      @(negedge clk);
      bus.seq_bit = b;
      bus.bit_vld = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.seq_bit = 1'b0;
      bus.bit_vld = 1'b0;
      bus.overlap = 1'b1;
      bus.pat_load = 1'b0;
      bus.pat_in = 4'b0000;
      bus.clr_cnt = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.tick !== 1'b0) begin
         errors++;
         $display("FAIL reset_tick: got %b expected 0", bus.tick);
      end
      checks++;
      if (bus.match_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d expected 0", bus.match_cnt);
      end
      checks++;
      if (bus.cnt_sat !== 1'b0) begin
         errors++;
         $display("FAIL reset_sat: got %b expected 0", bus.cnt_sat);
      end
      checks++;
      if (bus2.match_cnt !== 2'd0 || bus2.cnt_sat !== 1'b0) begin
         errors++;
         $display("FAIL reset_cnt2: got %0d/%b expected 0/0",
                  bus2.match_cnt, bus2.cnt_sat);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_overlap();
      logic [6:0] s;
      logic [6:0] e;
      s = 7'b1011011;
      e = 7'b0001001;
      bus.overlap = 1'b1;
      for (int i = 0; i < 7; i++) begin
         drive(s[6-i], 1'b1);
         checks++;
         if (bus.tick !== e[6-i]) begin
            errors++;
            $display("FAIL overlap_tick bit%0d: got %b expected %b",
                     i + 1, bus.tick, e[6-i]);
         end
      end
      checks++;
      if (bus.match_cnt !== 8'd2) begin
         errors++;
         $display("FAIL overlap_cnt: got %0d expected 2", bus.match_cnt);
      end
   endtask

   task automatic test_nonoverlap();
      logic [9:0] s;
      logic [9:0] e;
      s = 10'b1011011011;
      e = 10'b0001000001;
      do_reset();
      bus.overlap = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(s[9-i], 1'b1);
         checks++;
         if (bus.tick !== e[9-i]) begin
            errors++;
            $display("FAIL nonoverlap_tick bit%0d: got %b expected %b",
                     i + 1, bus.tick, e[9-i]);
         end
         if (i == 6) begin
            checks++;
            if (bus.match_cnt !== 8'd1) begin
               errors++;
               $display("FAIL nonoverlap_cnt7: got %0d expected 1",
                        bus.match_cnt);
            end
         end
      end
      checks++;
      if (bus.match_cnt !== 8'd2) begin
         errors++;
         $display("FAIL nonoverlap_cnt: got %0d expected 2", bus.match_cnt);
      end
   endtask

   task automatic test_gaps();
      logic [3:0] s;
      s = 4'b1011;
      do_reset();
      bus.overlap = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(s[3-i], 1'b1);
         checks++;
         if (bus.tick !== (i == 3)) begin
            errors++;
            $display("FAIL gaps_tick bit%0d: got %b expected %b",
                     i + 1, bus.tick, (i == 3));
         end
         for (int g = 0; g < 3; g++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (bus.tick !== 1'b0) begin
               errors++;
               $display("FAIL gaps_idle bit%0d gap%0d: got %b expected 0",
                        i + 1, g, bus.tick);
            end
         end
      end
      checks++;
      if (bus.match_cnt !== 8'd1) begin
         errors++;
         $display("FAIL gaps_cnt: got %0d expected 1", bus.match_cnt);
      end
   endtask

   task automatic test_pat_load();
      logic [5:0] e;
      e = 6'b000111;
      bus.overlap = 1'b1;
      bus.pat_in = 4'b1111;
      bus.pat_load = 1'b1;
      drive(1'b1, 1'b1);
      bus.pat_load = 1'b0;
      checks++;
      if (bus.tick !== 1'b0) begin
         errors++;
         $display("FAIL load_tick: got %b expected 0", bus.tick);
      end
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1);
         checks++;
         if (bus.tick !== e[5-i]) begin
            errors++;
            $display("FAIL load_ones_tick bit%0d: got %b expected %b",
                     i + 1, bus.tick, e[5-i]);
         end
      end
      checks++;
      if (bus.match_cnt !== 8'd4) begin
         errors++;
         $display("FAIL load_cnt: got %0d expected 4", bus.match_cnt);
      end
   endtask

   task automatic test_sat();
      int exp2;
      int exp1;
      do_reset();
      bus.overlap = 1'b1;
      bus.pat_in = 4'b1111;
      bus.pat_load = 1'b1;
      drive(1'b0, 1'b0);
      bus.pat_load = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         drive(1'b1, 1'b1);
         exp1 = (k >= 4) ? k - 3 : 0;
         exp2 = (exp1 > 3) ? 3 : exp1;
         checks++;
         if (bus2.match_cnt !== 2'(exp2)) begin
            errors++;
            $display("FAIL sat_cnt2 bit%0d: got %0d expected %0d",
                     k, bus2.match_cnt, exp2);
         end
         checks++;
         if (bus2.cnt_sat !== (exp2 == 3)) begin
            errors++;
            $display("FAIL sat_flag bit%0d: got %b expected %b",
                     k, bus2.cnt_sat, (exp2 == 3));
         end
         checks++;
         if (bus.match_cnt !== 8'(exp1)) begin
            errors++;
            $display("FAIL sat_cnt1 bit%0d: got %0d expected %0d",
                     k, bus.match_cnt, exp1);
         end
      end
      bus.clr_cnt = 1'b1;
      drive(1'b1, 1'b1);
      bus.clr_cnt = 1'b0;
      checks++;
      if (bus.tick !== 1'b1) begin
         errors++;
         $display("FAIL clr_tick: got %b expected 1", bus.tick);
      end
      checks++;
      if (bus.match_cnt !== 8'd0 || bus2.match_cnt !== 2'd0) begin
         errors++;
         $display("FAIL clr_cnt: got %0d/%0d expected 0/0",
                  bus.match_cnt, bus2.match_cnt);
      end
      checks++;
      if (bus2.cnt_sat !== 1'b0) begin
         errors++;
         $display("FAIL clr_sat: got %b expected 0", bus2.cnt_sat);
      end
   endtask

   task automatic test_mid_reset();
      logic [8:0] s;
      logic [3:0] t;
      s = 9'b101101101;
      t = 4'b1011;
      do_reset();
      bus.overlap = 1'b1;
      for (int i = 0; i < 9; i++)
         drive(s[8-i], 1'b1);
      checks++;
      if (bus.match_cnt !== 8'd2) begin
         errors++;
         $display("FAIL midrst_pre_cnt: got %0d expected 2", bus.match_cnt);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (bus.tick !== 1'b0 || bus.match_cnt !== 8'd0 ||
          bus.cnt_sat !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outs: got %b/%0d/%b expected 0/0/0",
                  bus.tick, bus.match_cnt, bus.cnt_sat);
      end
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(t[3-i], 1'b1);
         checks++;
         if (bus.tick !== (i == 3)) begin
            errors++;
            $display("FAIL midrst_tick bit%0d: got %b expected %b",
                     i + 1, bus.tick, (i == 3));
         end
      end
      checks++;
      if (bus.match_cnt !== 8'd1) begin
         errors++;
         $display("FAIL midrst_cnt: got %0d expected 1", bus.match_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_gaps();
      test_pat_load();
      test_sat();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/seq_det_param.md
# seq_det_param

Parametrised serial pattern detector, the successor to the fixed 4-bit "1011" detector. It matches a runtime-loadable pattern of PAT_W bits on a qualified serial input. The block selects overlapping or non-overlapping detection, produces a registered one-cycle match pulse, and keeps a saturating match counter. It sits on the serial data path after the bit-sampling logic; tick feeds downstream framing logic and match_cnt goes to status registers.

## Interface
- PAT_W, 4, pattern length in bits; legal range 2..32.
- PAT_DEFAULT, 4'b1011 (width PAT_W), pattern register reset value; bit PAT_W-1 is the first bit received.
- CNT_W, 8, width of match counter; legal range 1..32.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- sequence  in  1  serial data bit; sampled only when bit_vld=1.
- bit_vld  in  1  qualifies sequence for this cycle.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
- pat_load  in  1  load pat_in into pattern register.
- pat_in  in  PAT_W  new pattern; MSB is the first expected bit.
- clr_cnt  in  1  synchronous clear of match_cnt.
- tick  out  1  one-cycle pulse, one cycle after the bit that completes a match.
- match_cnt  out  CNT_W  number of matches since reset or clear; saturating.
- cnt_sat  out  1  high while match_cnt equals 2^CNT_W-1.

## Operation
- State registers:
  - hist[PAT_W-2:0]: last received bits, newest in LSB.
  - fill: 0..PAT_W-1, counts valid history bits and saturates at PAT_W-1.
  - pat[PAT_W-1:0]: current pattern.
- Window = {hist, sequence}. match = bit_vld & ~pat_load & (fill == PAT_W-1) & (window == pat).
- When bit_vld=1 and pat_load=0:
  - hist <= {hist[PAT_W-3:0], sequence}; for PAT_W=2, hist <= sequence.
  - fill <= min(fill+1, PAT_W-1).
- On match with overlap=0: fill <= 0, so history is discarded and the next match needs PAT_W fresh bits.
- On match with overlap=1: fill stays at PAT_W-1, so matches may share bits.
- When bit_vld=0: hist, fill and pat hold; no match is possible.
- pat_load=1:
  - pat <= pat_in and fill <= 0.
  - The sequence bit in that cycle is discarded even if bit_vld=1, and no match occurs.
  - hist contents are don't-care.
- match_cnt:
  - On match it increments, holding at 2^CNT_W-1 once reached.
  - clr_cnt has priority over a same-cycle match and sets match_cnt <= 0; tick still pulses for that match.
- cnt_sat = (match_cnt == all ones), driven combinationally from the register.
- Reset values:
  - pat=PAT_DEFAULT, hist=0, fill=0, tick=0, match_cnt=0, cnt_sat=0.
- Reset mid-stream discards partial history; detection restarts from an empty window after rst deasserts.

## Timing
- tick is registered: tick <= match. It is high for exactly the one cycle after the edge at which the completing bit was sampled. It never stays high two cycles unless consecutive valid bits each complete a match, which requires overlap=1.
- match_cnt updates on the same edge that raises tick.
- Minimum spacing between ticks:
  - overlap=1: 1 valid bit (e.g. all-ones pattern with an all-ones stream).
  - overlap=0: PAT_W valid bits.
- A pattern written by pat_load applies from the next cycle's bit onward. The first possible match is PAT_W valid bits later.
- Changing overlap mid-stream takes effect on the next match evaluation; current fill is not affected.
- No combinational path from inputs to outputs.

## Test plan
- Reset with defaults (PAT_W=4, pattern 1011), overlap=1, bit_vld=1 every cycle, stream 1,0,1,1,0,1,1 -> tick pulses after bits 4 and 7; match_cnt=2.
- Same stream with overlap=0 -> tick after bit 4 only; match_cnt=1. Append 0,1,1 (bits 8-10 of 1011011011) -> tick after bit 10; match_cnt=2.
- Stream 1,0,1,1 with bit_vld=0 inserted for 3 cycles between every bit -> single tick, one cycle after the 4th valid bit only; no tick during gaps.
- pat_load with pat_in=4'b1111, overlap=1, then six 1s -> ticks after valid bits 4, 5 and 6; a bit presented in the pat_load cycle is ignored.
- CNT_W=2, overlap=1, pattern 1111, ten 1s -> match_cnt 1,2,3 then holds at 3; cnt_sat=1 from the third match. clr_cnt asserted together with a match -> match_cnt=0 and tick=1 that cycle.
- Assert rst mid-pattern after 1,0,1 -> all outputs 0 immediately. After release, bit 1 alone gives no tick; a full 1,0,1,1 gives a tick.
